cache_mshr: RTL and testbench
=============================

Name: cache_mshr

Overview:
- Miss-status holding register (MSHR) file that lets the write-back D$ keep up to NUMMSHR line misses outstanding, instead of blocking on a single miss.
- Sits between the cache FSM/way-select logic and the bus cache interface.
- The cache presents a miss with its line address, victim way and R/W flag. The MSHR file merges secondary misses to an in-flight line, issues bus line fetches by handshake, and reports each completed fill so the cache can write the line and set the valid/dirty bits.

Parameters:
- PA_BITS, 56, physical address width.
- LINELEN, 512, cache line length in bits.
- NUMWAYS, 4, cache associativity; the victim way is carried one-hot.
- NUMMSHR, 4, number of entries (>=2).
- MAXMERGE, 3, maximum secondary misses merged per entry.
- Derived: LADRLEN = PA_BITS - $clog2(LINELEN/8); IDW = $clog2(NUMMSHR).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- AllocValid  in  1  new miss presented
- AllocAdr  in  LADRLEN  line address of the miss
- AllocWay  in  NUMWAYS  one-hot victim way
- AllocWrite  in  1  the miss is a store (line becomes dirty on fill)
- AllocReady  out  1  miss accepted this cycle (valid & ready = accept)
- AllocMerged  out  1  accepted miss merged into an existing entry
- AllocId  out  IDW  entry that allocated or merged
- BusReqValid  out  1  line fetch request pending
- BusReqAdr  out  LADRLEN  line address of the request
- BusReqId  out  IDW  entry id of the request
- BusReqReady  in  1  bus accepts the request
- BusFillValid  in  1  line fetch complete
- BusFillId  in  IDW  entry being completed
- FillDoneValid  out  1  fill retired (registered)
- FillDoneAdr  out  LADRLEN  line address of the retired fill
- FillDoneWay  out  NUMWAYS  way to write
- FillDoneDirty  out  1  any merged or primary miss was a store
- Full  out  1  no entry in FREE state
- Busy  out  1  any entry not FREE

Behaviour:
- Entry state machine:
  - FREE -> PEND on a primary allocation.
  - PEND -> ISSUED when its BusReq handshake completes.
  - ISSUED -> FREE on BusFillValid with a matching BusFillId; the entry is allocatable again the next cycle.
- Entry fields: Adr, Way, Dirty, MergeCnt (saturating at MAXMERGE).
- Match: AllocAdr equals the Adr of any non-FREE entry; at most one entry can match.
- Acceptance, in priority order:
  - Match on an entry that is being filled this cycle -> AllocReady=0 (stall one cycle).
  - Match with MergeCnt==MAXMERGE -> AllocReady=0.
  - Match otherwise -> AllocReady=1, AllocMerged=1, AllocId=matching entry; MergeCnt++; Dirty |= AllocWrite; AllocWay is ignored.
  - No match and Full -> AllocReady=0.
  - No match and not Full -> allocate the lowest-index FREE entry; AllocMerged=0; Dirty=AllocWrite; MergeCnt=0.
- AllocReady, AllocMerged and AllocId are combinational from the current state. They are valid regardless of AllocValid, with AllocId=0 when no entry applies.
- Issue:
  - BusReqValid is asserted when any entry is PEND; the lowest-index PEND entry drives BusReqAdr/BusReqId.
  - These outputs must stay stable until BusReqReady.
  - An entry allocated in cycle N can request no earlier than N+1.
- Fill at cycle N:
  - FillDoneValid=1 at N+1 for exactly one cycle, with FillDoneAdr, FillDoneWay and FillDoneDirty from the entry as it stood at N.
  - A write merged at cycle N is not possible, because a matching alloc stalls during a fill.
- A BusFillValid whose id is not ISSUED is ignored: no state change and no FillDoneValid.
- Simultaneous events:
  - Alloc, issue and fill on different entries in the same cycle all take effect.
  - An alloc cannot take the entry being freed that cycle.
- Reset:
  - All entries go FREE and MergeCnt=0.
  - All outputs read 0: AllocReady=0 (state-derived), BusReqValid=0, FillDoneValid=0, Full=0, Busy=0.
  - Fills arriving after reset are ignored under the rule above.
  - Reset mid-operation discards outstanding entries, with no FillDone.

Decomposition:
- Package cvw: typedef mshr_state_t enum {FREE, PEND, ISSUED}.
- Package cvw: struct mshr_entry_t {state, Adr, Way, Dirty, MergeCnt}.
- One sub-module, cache_mshr_entry: a single entry with state flop, match comparator and merge counter, instantiated NUMMSHR times.
- The top level holds the lowest-index priority encoders for allocation and issue, the fill decode, and the FillDone register.

Test Plan:
- Two misses to different lines with NUMMSHR=4, adr 0x100 then 0x200 -> AllocId 0 then 1, AllocMerged=0. BusReq 0x100/id0 is held until BusReqReady, then 0x200/id1.
- Primary read miss 0x100, then a write miss 0x100 -> AllocMerged=1, AllocId=0. A fill of id0 -> FillDoneValid one cycle later with FillDoneAdr=0x100 and FillDoneDirty=1.
- Four distinct misses fill all entries -> Full=1; a fifth miss to 0x500 sees AllocReady=0. A fill of id2 -> the 0x500 miss is accepted in the cycle after the fill with AllocId=2.
- Four misses to 0x100 with MAXMERGE=3 -> 1 primary plus 3 merges are accepted; a fifth sees AllocReady=0 until the fill completes.
- An alloc to 0x100 in the same cycle as the fill of id0 (0x100) -> AllocReady=0. Next cycle it is accepted as a primary into entry 0.
- Reset asserted while 2 entries are ISSUED -> next cycle Busy=0 and BusReqValid=0. A subsequent BusFillValid id0 produces no FillDoneValid.

Source files
------------

// File: rtl/cache_mshr_pkg.sv
// Shared types and default geometry for the D$ miss-status holding register file.
package cvw;
  localparam int MSHR_PA_BITS  = 56;
  localparam int MSHR_LINELEN  = 512;
  localparam int MSHR_NUMWAYS  = 4;
  localparam int MSHR_NUMMSHR  = 4;
  localparam int MSHR_MAXMERGE = 3;
  localparam int MSHR_LADRLEN  = MSHR_PA_BITS - $clog2(MSHR_LINELEN / 8);
  localparam int MSHR_MCW      = $clog2(MSHR_MAXMERGE + 1);

  typedef enum logic [1:0] {FREE, PEND, ISSUED} mshr_state_t;

  // Field view of one entry at the default geometry.
  typedef struct packed {
    mshr_state_t             state;
    logic [MSHR_LADRLEN-1:0] Adr;
    logic [MSHR_NUMWAYS-1:0] Way;
    logic                    Dirty;
    logic [MSHR_MCW-1:0]     MergeCnt;
  } mshr_entry_t;
endpackage

// File: rtl/cache_mshr_entry.sv
// One MSHR entry: lifecycle state, captured miss fields, address comparator
// and saturating merge counter.
module cache_mshr_entry
  import cvw::*;
#(
  parameter int LADRLEN  = MSHR_LADRLEN,
  parameter int NUMWAYS  = MSHR_NUMWAYS,
  parameter int MAXMERGE = MSHR_MAXMERGE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alloc,
  input  logic               merge,
  input  logic               issue,
  input  logic               fillSel,
  input  logic [LADRLEN-1:0] allocAdr,
  input  logic [NUMWAYS-1:0] allocWay,
  input  logic               allocWrite,
  output logic               isFree,
  output logic               isPend,
  output logic               match,
  output logic               saturated,
  output logic               filling,
  output logic [LADRLEN-1:0] adr,
  output logic [NUMWAYS-1:0] way,
  output logic               dirty
);
  localparam int MCW = $clog2(MAXMERGE + 1);

  mshr_state_t    state, stateNext;
  logic [MCW-1:0] mergeCnt;

  always_ff @(posedge clk) begin
    if (reset) state <= FREE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      FREE:    if (alloc)   stateNext = PEND;
      PEND:    if (issue)   stateNext = ISSUED;
      ISSUED:  if (fillSel) stateNext = FREE;
      default:              stateNext = FREE;
    endcase
  end

  always_comb begin
    isFree    = (state == FREE);
    isPend    = (state == PEND);
    match     = (state != FREE) && (adr == allocAdr);
    saturated = (mergeCnt == MCW'(MAXMERGE));
    filling   = (state == ISSUED) && fillSel;
  end

  // A merge keeps the primary miss's victim way; only dirtiness accumulates.
  always_ff @(posedge clk) begin
    if (reset) begin
      adr      <= '0;
      way      <= '0;
      dirty    <= 1'b0;
      mergeCnt <= '0;
    end else if (alloc) begin
      adr      <= allocAdr;
      way      <= allocWay;
      dirty    <= allocWrite;
      mergeCnt <= '0;
    end else if (merge) begin
      dirty <= dirty | allocWrite;
      if (!saturated) mergeCnt <= mergeCnt + MCW'(1);
    end
  end
endmodule

// File: rtl/cache_mshr.sv
// MSHR file for the write-back D$: merges secondary misses, issues line
// fetches to the bus in lowest-index order and reports completed fills.
module cache_mshr
  import cvw::*;
#(
  parameter int PA_BITS  = MSHR_PA_BITS,
  parameter int LINELEN  = MSHR_LINELEN,
  parameter int NUMWAYS  = MSHR_NUMWAYS,
  parameter int NUMMSHR  = MSHR_NUMMSHR,
  parameter int MAXMERGE = MSHR_MAXMERGE,
  localparam int LADRLEN = PA_BITS - $clog2(LINELEN / 8),
  localparam int IDW     = $clog2(NUMMSHR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               AllocValid,
  input  logic [LADRLEN-1:0] AllocAdr,
  input  logic [NUMWAYS-1:0] AllocWay,
  input  logic               AllocWrite,
  output logic               AllocReady,
  output logic               AllocMerged,
  output logic [IDW-1:0]     AllocId,
  output logic               BusReqValid,
  output logic [LADRLEN-1:0] BusReqAdr,
  output logic [IDW-1:0]     BusReqId,
  input  logic               BusReqReady,
  input  logic               BusFillValid,
  input  logic [IDW-1:0]     BusFillId,
  output logic               FillDoneValid,
  output logic [LADRLEN-1:0] FillDoneAdr,
  output logic [NUMWAYS-1:0] FillDoneWay,
  output logic               FillDoneDirty,
  output logic               Full,
  output logic               Busy
);
  logic [NUMMSHR-1:0] isFree, isPend, match, saturated, filling;
  logic [NUMMSHR-1:0] allocSel, mergeSel, issueSel, fillSel;
  logic [LADRLEN-1:0] entAdr [NUMMSHR];
  logic [NUMWAYS-1:0] entWay [NUMMSHR];
  logic [NUMMSHR-1:0] entDirty;
  logic [IDW-1:0]     freeId, matchId, pendId, reqId, lockIdReg;
  logic               freeFound, lockReg, allocTake, mergeTake;
  logic [LADRLEN-1:0] fillAdr;
  logic [NUMWAYS-1:0] fillWay;
  logic               fillDirty;

  assign allocTake = AllocValid & AllocReady & ~AllocMerged;
  assign mergeTake = AllocValid & AllocReady & AllocMerged;

  for (genvar gi = 0; gi < NUMMSHR; gi++) begin : gEntry
    assign allocSel[gi] = allocTake & (freeId == IDW'(gi));
    assign mergeSel[gi] = mergeTake & match[gi];
    assign issueSel[gi] = BusReqValid & BusReqReady & (reqId == IDW'(gi));
    assign fillSel[gi]  = BusFillValid & (BusFillId == IDW'(gi));

    cache_mshr_entry #(
      .LADRLEN (LADRLEN),
      .NUMWAYS (NUMWAYS),
      .MAXMERGE(MAXMERGE)
    ) uEntry (
      .clk       (clk),
      .reset     (reset),
      .alloc     (allocSel[gi]),
      .merge     (mergeSel[gi]),
      .issue     (issueSel[gi]),
      .fillSel   (fillSel[gi]),
      .allocAdr  (AllocAdr),
      .allocWay  (AllocWay),
      .allocWrite(AllocWrite),
      .isFree    (isFree[gi]),
      .isPend    (isPend[gi]),
      .match     (match[gi]),
      .saturated (saturated[gi]),
      .filling   (filling[gi]),
      .adr       (entAdr[gi]),
      .way       (entWay[gi]),
      .dirty     (entDirty[gi])
    );
  end

  // Lowest-index encoders; at most one entry can match, so matchId is exact.
  always_comb begin
    freeId    = '0;
    freeFound = 1'b0;
    pendId    = '0;
    matchId   = '0;
    for (int i = NUMMSHR - 1; i >= 0; i--) begin
      if (isFree[i]) begin
        freeId    = IDW'(i);
        freeFound = 1'b1;
      end
      if (isPend[i]) pendId  = IDW'(i);
      if (match[i])  matchId = IDW'(i);
    end
  end

  always_comb begin
    AllocReady  = 1'b0;
    AllocMerged = 1'b0;
    AllocId     = '0;
    if (!reset) begin
      if (|match) begin
        if (!(|(match & filling)) && !(|(match & saturated))) begin
          AllocReady  = 1'b1;
          AllocMerged = 1'b1;
          AllocId     = matchId;
        end
      end else if (freeFound) begin
        AllocReady = 1'b1;
        AllocId    = freeId;
      end
    end
  end

  // A stalled request stays pinned even if a lower entry becomes PEND meanwhile.
  assign reqId       = lockReg ? lockIdReg : pendId;
  assign BusReqValid = ~reset & (|isPend);
  assign BusReqId    = BusReqValid ? reqId : '0;
  assign BusReqAdr   = BusReqValid ? entAdr[reqId] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      lockReg   <= 1'b0;
      lockIdReg <= '0;
    end else begin
      lockReg   <= BusReqValid & ~BusReqReady;
      lockIdReg <= reqId;
    end
  end

  assign Full = ~reset & ~(|isFree);
  assign Busy = ~reset & ~(&isFree);

  always_comb begin
    fillAdr   = '0;
    fillWay   = '0;
    fillDirty = 1'b0;
    for (int i = 0; i < NUMMSHR; i++) begin
      if (filling[i]) begin
        fillAdr   = entAdr[i];
        fillWay   = entWay[i];
        fillDirty = entDirty[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      FillDoneValid <= 1'b0;
      FillDoneAdr   <= '0;
      FillDoneWay   <= '0;
      FillDoneDirty <= 1'b0;
    end else begin
      FillDoneValid <= |filling;
      FillDoneAdr   <= fillAdr;
      FillDoneWay   <= fillWay;
      FillDoneDirty <= fillDirty;
    end
  end
endmodule

// File: tb/tb_cache_mshr.sv
// Self-checking bench for cache_mshr: directed scenarios plus a randomized
// run against a behavioural model of the MSHR rules.
module tb_cache_mshr;
  localparam int LADR = 50;
  localparam int NW   = 4;
  localparam int IDW  = 2;
  localparam int NM   = 4;
  localparam int MAXM = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            AllocValid;
  logic [LADR-1:0] AllocAdr;
  logic [NW-1:0]   AllocWay;
  logic            AllocWrite;
  logic            AllocReady;
  logic            AllocMerged;
  logic [IDW-1:0]  AllocId;
  logic            BusReqValid;
  logic [LADR-1:0] BusReqAdr;
  logic [IDW-1:0]  BusReqId;
  logic            BusReqReady;
  logic            BusFillValid;
  logic [IDW-1:0]  BusFillId;
  logic            FillDoneValid;
  logic [LADR-1:0] FillDoneAdr;
  logic [NW-1:0]   FillDoneWay;
  logic            FillDoneDirty;
  logic            Full;
  logic            Busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_mshr dut (
    .clk          (clk),
    .reset        (reset),
    .AllocValid   (AllocValid),
    .AllocAdr     (AllocAdr),
    .AllocWay     (AllocWay),
    .AllocWrite   (AllocWrite),
    .AllocReady   (AllocReady),
    .AllocMerged  (AllocMerged),
    .AllocId      (AllocId),
    .BusReqValid  (BusReqValid),
    .BusReqAdr    (BusReqAdr),
    .BusReqId     (BusReqId),
    .BusReqReady  (BusReqReady),
    .BusFillValid (BusFillValid),
    .BusFillId    (BusFillId),
    .FillDoneValid(FillDoneValid),
    .FillDoneAdr  (FillDoneAdr),
    .FillDoneWay  (FillDoneWay),
    .FillDoneDirty(FillDoneDirty),
    .Full         (Full),
    .Busy         (Busy)
  );

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    AllocValid   = 1'b0;
    AllocAdr     = '0;
    AllocWay     = '0;
    AllocWrite   = 1'b0;
    BusReqReady  = 1'b0;
    BusFillValid = 1'b0;
    BusFillId    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    clk_step();
    clk_step();
    reset = 1'b0;
  endtask

  task automatic alloc(input logic [LADR-1:0] a, input logic [NW-1:0] w, input logic wr);
    AllocValid = 1'b1;
    AllocAdr   = a;
    AllocWay   = w;
    AllocWrite = wr;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (AllocReady !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b expected 0", AllocReady); end
    checks++; if (BusReqValid !== 1'b0) begin errors++; $display("FAIL rst_reqvalid: got %0b expected 0", BusReqValid); end
    checks++; if (FillDoneValid !== 1'b0) begin errors++; $display("FAIL rst_filldone: got %0b expected 0", FillDoneValid); end
    checks++; if (Full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b expected 0", Full); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", Busy); end
    clk_step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (AllocReady !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0b expected 1", AllocReady); end
    checks++; if (AllocId !== 2'd0) begin errors++; $display("FAIL post_rst_id: got %0d expected 0", AllocId); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %0b expected 0", Busy); end
    $display("test_reset done");
  endtask

  task automatic test_two_misses();
    do_reset();
    alloc(50'h100, 4'b0001, 1'b0);
    @(negedge clk);
    checks++; if (AllocReady !== 1'b1 || AllocMerged !== 1'b0 || AllocId !== 2'd0) begin errors++; $display("FAIL two_first: got rdy=%0b mrg=%0b id=%0d expected 1 0 0", AllocReady, AllocMerged, AllocId); end
    checks++; if (BusReqValid !== 1'b0) begin errors++; $display("FAIL two_noearly_req: got %0b expected 0", BusReqValid); end
    clk_step();
    alloc(50'h200, 4'b0010, 1'b0);
    @(negedge clk);
    checks++; if (AllocReady !== 1'b1 || AllocMerged !== 1'b0 || AllocId !== 2'd1) begin errors++; $display("FAIL two_second: got rdy=%0b mrg=%0b id=%0d expected 1 0 1", AllocReady, AllocMerged, AllocId); end
    checks++; if (BusReqValid !== 1'b1 || BusReqAdr !== 50'h100 || BusReqId !== 2'd0) begin errors++; $display("FAIL two_req0: got v=%0b adr=%0h id=%0d expected 1 100 0", BusReqValid, BusReqAdr, BusReqId); end
    clk_step();
    AllocValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (BusReqValid !== 1'b1 || BusReqAdr !== 50'h100 || BusReqId !== 2'd0) begin errors++; $display("FAIL two_hold: got v=%0b adr=%0h id=%0d expected 1 100 0", BusReqValid, BusReqAdr, BusReqId); end
      clk_step();
    end
    BusReqReady = 1'b1;
    @(negedge clk);
    checks++; if (BusReqAdr !== 50'h100 || BusReqId !== 2'd0) begin errors++; $display("FAIL two_hs0: got adr=%0h id=%0d expected 100 0", BusReqAdr, BusReqId); end
    clk_step();
    @(negedge clk);
    checks++; if (BusReqValid !== 1'b1 || BusReqAdr !== 50'h200 || BusReqId !== 2'd1) begin errors++; $display("FAIL two_req1: got v=%0b adr=%0h id=%0d expected 1 200 1", BusReqValid, BusReqAdr, BusReqId); end
    clk_step();
    BusReqReady = 1'b0;
    @(negedge clk);
    checks++; if (BusReqValid !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL two_drained: got v=%0b busy=%0b expected 0 1", BusReqValid, Busy); end
    $display("test_two_misses done");
  endtask

  task automatic test_merge_dirty();
    do_reset();
    alloc(50'h100, 4'b0010, 1'b0);
    clk_step();
    alloc(50'h100, 4'b1000, 1'b1);
    @(negedge clk);
    checks++; if (AllocReady !== 1'b1 || AllocMerged !== 1'b1 || AllocId !== 2'd0) begin errors++; $display("FAIL merge_accept: got rdy=%0b mrg=%0b id=%0d expected 1 1 0", AllocReady, AllocMerged, AllocId); end
    clk_step();
    AllocValid  = 1'b0;
    BusReqReady = 1'b1;
    clk_step();
    BusReqReady  = 1'b0;
    BusFillValid = 1'b1;
    BusFillId    = 2'd0;
    @(negedge clk);
    checks++; if (FillDoneValid !== 1'b0) begin errors++; $display("FAIL merge_fd_early: got %0b expected 0", FillDoneValid); end
    clk_step();
    BusFillValid = 1'b0;
    @(negedge clk);
    checks++; if (FillDoneValid !== 1'b1 || FillDoneAdr !== 50'h100 || FillDoneDirty !== 1'b1 || FillDoneWay !== 4'b0010) begin errors++; $display("FAIL merge_fd: got v=%0b adr=%0h d=%0b way=%0b expected 1 100 1 0010", FillDoneValid, FillDoneAdr, FillDoneDirty, FillDoneWay); end
    clk_step();
    @(negedge clk);
    checks++; if (FillDoneValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL merge_fd_once: got v=%0b busy=%0b expected 0 0", FillDoneValid, Busy); end
    $display("test_merge_dirty done");
  endtask

  task automatic test_full();
    logic [NW-1:0] w;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w = '0;
      w[i] = 1'b1;
      alloc(LADR'(32'h100 * (i + 1)), w, 1'b0);
      @(negedge clk);
      checks++; if (AllocReady !== 1'b1 || AllocId !== IDW'(i)) begin errors++; $display("FAIL full_fill%0d: got rdy=%0b id=%0d expected 1 %0d", i, AllocReady, AllocId, i); end
      clk_step();
    end
    alloc(50'h500, 4'b0100, 1'b1);
    @(negedge clk);
    checks++; if (Full !== 1'b1 || AllocReady !== 1'b0) begin errors++; $display("FAIL full_stall: got full=%0b rdy=%0b expected 1 0", Full, AllocReady); end
    BusReqReady = 1'b1;
    repeat (4) clk_step();
    BusReqReady  = 1'b0;
    BusFillValid = 1'b1;
    BusFillId    = 2'd2;
    @(negedge clk);
    checks++; if (AllocReady !== 1'b0) begin errors++; $display("FAIL full_fillcycle: got rdy=%0b expected 0", AllocReady); end
    clk_step();
    BusFillValid = 1'b0;
    @(negedge clk);
    checks++; if (AllocReady !== 1'b1 || AllocMerged !== 1'b0 || AllocId !== 2'd2) begin errors++; $display("FAIL full_reuse: got rdy=%0b mrg=%0b id=%0d expected 1 0 2", AllocReady, AllocMerged, AllocId); end
    checks++; if (FillDoneValid !== 1'b1 || FillDoneAdr !== 50'h300 || FillDoneWay !== 4'b0100) begin errors++; $display("FAIL full_fd: got v=%0b adr=%0h way=%0b expected 1 300 0100", FillDoneValid, FillDoneAdr, FillDoneWay); end
    clk_step();
    AllocValid = 1'b0;
    @(negedge clk);
    checks++; if (Full !== 1'b1) begin errors++; $display("FAIL full_again: got %0b expected 1", Full); end
    $display("test_full done");
  endtask

  task automatic test_merge_sat();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(50'h100, 4'b0001, (i == 2));
      @(negedge clk);
      checks++; if (AllocReady !== 1'b1 || AllocMerged !== (i != 0) || AllocId !== 2'd0) begin errors++; $display("FAIL sat_acc%0d: got rdy=%0b mrg=%0b id=%0d expected 1 %0b 0", i, AllocReady, AllocMerged, AllocId, (i != 0)); end
      clk_step();
    end
    BusReqReady = 1'b1;
    @(negedge clk);
    checks++; if (AllocReady !== 1'b0) begin errors++; $display("FAIL sat_stall: got %0b expected 0", AllocReady); end
    clk_step();
    BusReqReady  = 1'b0;
    BusFillValid = 1'b1;
    BusFillId    = 2'd0;
    @(negedge clk);
    checks++; if (AllocReady !== 1'b0) begin errors++; $display("FAIL sat_fillstall: got %0b expected 0", AllocReady); end
    clk_step();
    BusFillValid = 1'b0;
    @(negedge clk);
    checks++; if (AllocReady !== 1'b1 || AllocMerged !== 1'b0 || AllocId !== 2'd0) begin errors++; $display("FAIL sat_reprimary: got rdy=%0b mrg=%0b id=%0d expected 1 0 0", AllocReady, AllocMerged, AllocId); end
    checks++; if (FillDoneValid !== 1'b1 || FillDoneDirty !== 1'b1) begin errors++; $display("FAIL sat_fd: got v=%0b d=%0b expected 1 1", FillDoneValid, FillDoneDirty); end
    clk_step();
    AllocValid = 1'b0;
    $display("test_merge_sat done");
  endtask

  task automatic test_fill_stall();
    do_reset();
    alloc(50'h100, 4'b0010, 1'b0);
    clk_step();
    AllocValid  = 1'b0;
    BusReqReady = 1'b1;
    clk_step();
    BusReqReady = 1'b0;
    alloc(50'h100, 4'b0100, 1'b0);
    BusFillValid = 1'b1;
    BusFillId    = 2'd0;
    @(negedge clk);
    checks++; if (AllocReady !== 1'b0 || AllocId !== 2'd0) begin errors++; $display("FAIL stall_samecycle: got rdy=%0b id=%0d expected 0 0", AllocReady, AllocId); end
    clk_step();
    BusFillValid = 1'b0;
    @(negedge clk);
    checks++; if (AllocReady !== 1'b1 || AllocMerged !== 1'b0 || AllocId !== 2'd0) begin errors++; $display("FAIL stall_next: got rdy=%0b mrg=%0b id=%0d expected 1 0 0", AllocReady, AllocMerged, AllocId); end
    checks++; if (FillDoneValid !== 1'b1 || FillDoneDirty !== 1'b0 || FillDoneWay !== 4'b0010) begin errors++; $display("FAIL stall_fd: got v=%0b d=%0b way=%0b expected 1 0 0010", FillDoneValid, FillDoneDirty, FillDoneWay); end
    clk_step();
    AllocValid = 1'b0;
    @(negedge clk);
    checks++; if (BusReqValid !== 1'b1 || BusReqAdr !== 50'h100 || BusReqId !== 2'd0) begin errors++; $display("FAIL stall_req: got v=%0b adr=%0h id=%0d expected 1 100 0", BusReqValid, BusReqAdr, BusReqId); end
    $display("test_fill_stall done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc(50'h100, 4'b0001, 1'b0);
    clk_step();
    alloc(50'h200, 4'b0010, 1'b1);
    BusReqReady = 1'b1;
    clk_step();
    AllocValid = 1'b0;
    clk_step();
    BusReqReady = 1'b0;
    @(negedge clk);
    checks++; if (Busy !== 1'b1 || BusReqValid !== 1'b0) begin errors++; $display("FAIL mid_pre: got busy=%0b v=%0b expected 1 0", Busy, BusReqValid); end
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (Busy !== 1'b0 || BusReqValid !== 1'b0 || Full !== 1'b0 || FillDoneValid !== 1'b0) begin errors++; $display("FAIL mid_post: got busy=%0b v=%0b full=%0b fd=%0b expected 0 0 0 0", Busy, BusReqValid, Full, FillDoneValid); end
    BusFillValid = 1'b1;
    BusFillId    = 2'd0;
    clk_step();
    BusFillValid = 1'b0;
    @(negedge clk);
    checks++; if (FillDoneValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL mid_stalefill: got fd=%0b busy=%0b expected 0 0", FillDoneValid, Busy); end
    $display("test_reset_mid done");
  endtask

  // Reference model: per-entry life cycle kept as 0=free, 1=waiting for bus, 2=on the bus.
  task automatic test_random();
    int              mSt [NM];
    logic [LADR-1:0] mAdr [NM];
    logic [NW-1:0]   mWay [NM];
    logic            mDirty [NM];
    int              mCnt [NM];
    int              prevReq;
    bit              fdV;
    logic [LADR-1:0] fdAdr;
    logic [NW-1:0]   fdWay;
    logic            fdDirty;
    int              matchIdx, fillIdx, freeIdx, reqIdx, eId, nFree;
    bit              eReady, eMerged;
    do_reset();
    for (int i = 0; i < NM; i++) begin
      mSt[i] = 0; mAdr[i] = '0; mWay[i] = '0; mDirty[i] = 1'b0; mCnt[i] = 0;
    end
    prevReq = -1;
    fdV = 1'b0; fdAdr = '0; fdWay = '0; fdDirty = 1'b0;
    for (int c = 0; c < 600; c++) begin
      AllocValid   = ($urandom_range(0, 99) < 60);
      AllocAdr     = LADR'(32'h100 * $urandom_range(1, 6));
      AllocWay     = '0;
      AllocWay[$urandom_range(0, NW - 1)] = 1'b1;
      AllocWrite   = 1'($urandom_range(0, 1));
      BusReqReady  = ($urandom_range(0, 99) < 45);
      BusFillValid = ($urandom_range(0, 99) < 35);
      BusFillId    = IDW'($urandom_range(0, NM - 1));

      matchIdx = -1; freeIdx = -1; reqIdx = -1; nFree = 0;
      for (int i = NM - 1; i >= 0; i--) begin
        if (mSt[i] != 0 && mAdr[i] == AllocAdr) matchIdx = i;
        if (mSt[i] == 0) begin freeIdx = i; nFree++; end
        if (mSt[i] == 1) reqIdx = i;
      end
      if (prevReq >= 0) reqIdx = prevReq;
      fillIdx = (BusFillValid && mSt[BusFillId] == 2) ? int'(BusFillId) : -1;
      eReady = 1'b0; eMerged = 1'b0; eId = 0;
      if (matchIdx >= 0) begin
        if (matchIdx != fillIdx && mCnt[matchIdx] < MAXM) begin
          eReady = 1'b1; eMerged = 1'b1; eId = matchIdx;
        end
      end else if (freeIdx >= 0) begin
        eReady = 1'b1; eId = freeIdx;
      end

      @(negedge clk);
      checks++; if (AllocReady !== eReady) begin errors++; $display("FAIL rnd_ready c=%0d: got %0b expected %0b", c, AllocReady, eReady); end
      checks++; if (AllocMerged !== eMerged) begin errors++; $display("FAIL rnd_merged c=%0d: got %0b expected %0b", c, AllocMerged, eMerged); end
      checks++; if (AllocId !== IDW'(eId)) begin errors++; $display("FAIL rnd_id c=%0d: got %0d expected %0d", c, AllocId, eId); end
      checks++; if (BusReqValid !== (reqIdx >= 0)) begin errors++; $display("FAIL rnd_reqvalid c=%0d: got %0b expected %0b", c, BusReqValid, (reqIdx >= 0)); end
      if (reqIdx >= 0) begin
        checks++; if (BusReqId !== IDW'(reqIdx) || BusReqAdr !== mAdr[reqIdx]) begin errors++; $display("FAIL rnd_req c=%0d: got id=%0d adr=%0h expected %0d %0h", c, BusReqId, BusReqAdr, reqIdx, mAdr[reqIdx]); end
      end
      checks++; if (Full !== (nFree == 0) || Busy !== (nFree != NM)) begin errors++; $display("FAIL rnd_fullbusy c=%0d: got full=%0b busy=%0b expected %0b %0b", c, Full, Busy, (nFree == 0), (nFree != NM)); end
      checks++; if (FillDoneValid !== fdV) begin errors++; $display("FAIL rnd_fdvalid c=%0d: got %0b expected %0b", c, FillDoneValid, fdV); end
      if (fdV) begin
        checks++; if (FillDoneAdr !== fdAdr || FillDoneWay !== fdWay || FillDoneDirty !== fdDirty) begin errors++; $display("FAIL rnd_fd c=%0d: got adr=%0h way=%0b d=%0b expected %0h %0b %0b", c, FillDoneAdr, FillDoneWay, FillDoneDirty, fdAdr, fdWay, fdDirty); end
        $display("fill done adr=%0h way=%0b dirty=%0b", FillDoneAdr, FillDoneWay, FillDoneDirty);
      end

      @(posedge clk);
      fdV = (fillIdx >= 0);
      if (fillIdx >= 0) begin
        fdAdr = mAdr[fillIdx]; fdWay = mWay[fillIdx]; fdDirty = mDirty[fillIdx];
        mSt[fillIdx] = 0;
      end
      if (reqIdx >= 0 && BusReqReady) mSt[reqIdx] = 2;
      prevReq = (reqIdx >= 0 && !BusReqReady) ? reqIdx : -1;
      if (AllocValid && eReady) begin
        if (eMerged) begin
          mDirty[eId] = mDirty[eId] | AllocWrite;
          mCnt[eId]   = mCnt[eId] + 1;
        end else begin
          mSt[eId] = 1; mAdr[eId] = AllocAdr; mWay[eId] = AllocWay;
          mDirty[eId] = AllocWrite; mCnt[eId] = 0;
        end
      end
      #1;
    end
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_two_misses();
    test_merge_dirty();
    test_full();
    test_merge_sat();
    test_fill_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
